// File: rtl/convolution_filter_pkg.sv
// Shared types and arithmetic helpers for the streaming 2-D convolution filter.
// Holds the FSM state type, the accumulator sizing rule and the output shift/saturate step.
package convolution_filter_pkg;

  typedef enum logic {
    STREAM = 1'b0,
    FLUSH  = 1'b1
  } state_t;

  // Wide enough that summing every full-scale product of the kernel can never overflow.
  function automatic int acc_width(input int w, input int kh, input int kw);
    return 2 * w + 1 + $clog2(kh * kw);
  endfunction

  // Arithmetic right shift (rounds toward minus infinity), then clamp into 0..2^w-1.
  function automatic logic [63:0] shift_clamp(input logic signed [63:0] acc,
                                              input int                 frac,
                                              input int                 w);
    logic signed [63:0] shifted;
    logic signed [63:0] max_val;
    shifted = acc >>> frac;
    max_val = (64'sd1 <<< w) - 64'sd1;
    if (shifted < 64'sd0) begin
      return '0;
    end else if (shifted > max_val) begin
      return max_val;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of delay: a circular buffer that returns the pixel written DEPTH advances ago.
// Contents are never reset; the top level masks any stale data at the frame borders.
module conv_line_buffer
  import convolution_filter_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Read happens before the write at the same slot, giving exactly DEPTH advances of delay.
  assign dout = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/convolution_filter.sv
// Streaming raster-order 2-D convolution with zero padding and saturated unsigned output.
// One output per input pixel; the final lag's worth of outputs is drained by flushing zeros.
module convolution_filter
  import convolution_filter_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int KERNEL_H   = 3,
  parameter int KERNEL_W   = 3,
  parameter int W          = 8,
  parameter int W_FRAC     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic [W-1:0]        x_data,
  output logic                y_valid,
  input  logic                y_ready,
  output logic [W-1:0]        y_data,
  input  logic signed [W-1:0] kernel [KERNEL_H][KERNEL_W]
);

  localparam int N      = IMG_WIDTH * IMG_HEIGHT;
  localparam int KH2    = KERNEL_H / 2;
  localparam int KW2    = KERNEL_W / 2;
  localparam int L      = KH2 * IMG_WIDTH + KW2;
  localparam int CNT_W  = $clog2(N + L + 1);
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT + 1) : 1;
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ACC_W  = acc_width(W, KERNEL_H, KERNEL_W);
  localparam int PROD_W = 2 * W + 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
  logic [ROW_W-1:0]     out_row_q, out_row_d;
  logic [COL_W-1:0]     out_col_q, out_col_d;
  logic                 y_valid_q, y_valid_d;
  logic [W-1:0]         y_data_q, y_data_d;

  logic [W-1:0]         win_q    [KERNEL_H][KERNEL_W];
  logic [W-1:0]         win_d    [KERNEL_H][KERNEL_W];
  logic [W-1:0]         win_next [KERNEL_H][KERNEL_W];
  logic [W-1:0]         col_in   [KERNEL_H];
  logic [W-1:0]         lb_in    [KERNEL_H-1];
  logic [W-1:0]         lb_out   [KERNEL_H-1];

  logic                 slot_free;
  logic                 adv;
  logic [W-1:0]         pix_in;
  logic signed [ACC_W-1:0] acc_sum;

  assign slot_free = !y_valid_q || y_ready;
  assign x_ready   = (state_q == STREAM) && slot_free;
  assign adv       = (state_q == STREAM) ? (x_valid && slot_free) : slot_free;
  assign pix_in    = (state_q == STREAM) ? x_data : '0;
  assign y_valid   = y_valid_q;
  assign y_data    = y_data_q;

  // Line buffers are chained: buffer m delays the incoming stream by m+1 lines.
  for (genvar m = 0; m < KERNEL_H - 1; m++) begin : g_lines
    if (m == 0) begin : g_first
      assign lb_in[m] = pix_in;
    end else begin : g_chain
      assign lb_in[m] = lb_out[m-1];
    end
    conv_line_buffer #(
      .DEPTH(IMG_WIDTH),
      .W    (W)
    ) u_line (
      .clk (clk),
      .rst (rst),
      .adv (adv),
      .din (lb_in[m]),
      .dout(lb_out[m])
    );
  end

  for (genvar i = 0; i < KERNEL_H; i++) begin : g_col_in
    if (i == KERNEL_H - 1) begin : g_newest
      assign col_in[i] = pix_in;
    end else begin : g_delayed
      assign col_in[i] = lb_out[KERNEL_H-2-i];
    end
  end

  always_comb begin
    for (int i = 0; i < KERNEL_H; i++) begin
      for (int j = 0; j < KERNEL_W - 1; j++) begin
        win_next[i][j] = win_q[i][j+1];
      end
      win_next[i][KERNEL_W-1] = col_in[i];
    end
  end

  // The MAC works on the post-advance window so the result is registered on the same edge.
  always_comb begin
    int                  row;
    int                  col;
    logic signed [W:0]   pix_s;
    logic signed [PROD_W-1:0] prod;
    acc_sum = '0;
    for (int i = 0; i < KERNEL_H; i++) begin
      for (int j = 0; j < KERNEL_W; j++) begin
        row   = int'(out_row_q) + i - KH2;
        col   = int'(out_col_q) + j - KW2;
        pix_s = {1'b0, win_next[i][j]};
        prod  = PROD_W'(pix_s) * PROD_W'(kernel[i][j]);
        if (row >= 0 && row < IMG_HEIGHT && col >= 0 && col < IMG_WIDTH) begin
          acc_sum = acc_sum + ACC_W'(prod);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    win_d     = win_q;

    if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end

    if (adv) begin
      win_d    = win_next;
      in_cnt_d = in_cnt_q + 1'b1;

      if (in_cnt_q >= CNT_W'(L)) begin
        y_valid_d = 1'b1;
        y_data_d  = W'(shift_clamp(64'(acc_sum), W_FRAC, W));
        if (out_col_q == COL_W'(IMG_WIDTH - 1)) begin
          out_col_d = '0;
          out_row_d = out_row_q + 1'b1;
        end else begin
          out_col_d = out_col_q + 1'b1;
        end
      end

      if (state_q == STREAM && in_cnt_q == CNT_W'(N - 1)) begin
        state_d = FLUSH;
      end

      // Last output of the frame: rearm every counter for the next frame.
      if (state_q == FLUSH && in_cnt_q == CNT_W'(N + L - 1)) begin
        state_d   = STREAM;
        in_cnt_d  = '0;
        out_row_d = '0;
        out_col_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= STREAM;
      in_cnt_q  <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      for (int i = 0; i < KERNEL_H; i++) begin
        for (int j = 0; j < KERNEL_W; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      win_q     <= win_d;
    end
  end

endmodule

// File: tb/tb_convolution_filter.sv
// Self-checking bench for convolution_filter on an 8x6 image with a 3x3 kernel.
// Two instances share all stimulus: one with W_FRAC = 0, one with W_FRAC = 3.
module tb_convolution_filter;

  localparam int IW   = 8;
  localparam int IH   = 6;
  localparam int NPIX = IW * IH;
  localparam int LAG  = IW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              x_valid;
  logic              x_ready;
  logic              x_ready_f;
  logic [7:0]        x_data;
  logic              y_valid;
  logic              y_valid_f;
  logic              y_ready;
  logic [7:0]        y_data;
  logic [7:0]        y_data_f;
  logic signed [7:0] kern [3][3];

  int checks = 0;
  int errors = 0;

  int img [2*NPIX];
  int exp_q[$];
  int exp_f[$];
  int got;
  int acc_cnt;
  bit first_seen;
  bit rand_ready;
  bit gaps;
  bit prev_stall;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  convolution_filter #(
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .KERNEL_H(3), .KERNEL_W(3), .W(8), .W_FRAC(0)
  ) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .kernel(kern)
  );

  convolution_filter #(
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .KERNEL_H(3), .KERNEL_W(3), .W(8), .W_FRAC(3)
  ) dut_frac (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready_f), .x_data(x_data),
    .y_valid(y_valid_f), .y_ready(y_ready), .y_data(y_data_f), .kernel(kern)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Direct definition of the zero-padded convolution, floor shift and clamp.
  function automatic int refOut(input int base, input int r, input int c, input int frac);
    int sum = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int rr = r + i - 1;
        int cc = c + j - 1;
        if (rr >= 0 && rr < IH && cc >= 0 && cc < IW)
          sum += int'(kern[i][j]) * img[base + rr*IW + cc];
      end
    end
    sum = sum >>> frac;
    if (sum < 0) sum = 0;
    if (sum > 255) sum = 255;
    return sum;
  endfunction

  task automatic buildExpected(input int base);
    for (int k = 0; k < NPIX; k++) begin
      exp_q.push_back(refOut(base, k / IW, k % IW, 0));
      exp_f.push_back(refOut(base, k / IW, k % IW, 3));
    end
  endtask

  task automatic startTest();
    exp_q.delete();
    exp_f.delete();
    got        = 0;
    acc_cnt    = 0;
    first_seen = 1'b0;
  endtask

  task automatic setKernel(input int k0, input int k1, input int k2, input int k3,
                           input int k4, input int k5, input int k6, input int k7,
                           input int k8);
    int k [9];
    k = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};
    for (int i = 0; i < 9; i++) kern[i/3][i%3] = 8'(k[i]);
  endtask

  // Drives count pixels starting at img[base]; inputs change 1 time unit after the rising edge.
  task automatic applyStimulus(input int base, input int count);
    for (int k = 0; k < count; k++) begin
      bit accepted = 1'b0;
      int waited = 0;
      if (gaps) begin
        x_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      x_valid = 1'b1;
      x_data  = 8'(img[base + k]);
      while (!accepted) begin
        @(negedge clk);
        accepted = x_ready;
        @(posedge clk); #1;
        if (!accepted) begin
          waited++;
          if (waited > 500) begin
            checkOutput("x_ready_timeout", 0, 1);
            x_valid = 1'b0;
            return;
          end
        end
      end
      acc_cnt++;
    end
    x_valid = 1'b0;
  endtask

  task automatic waitOutputs(input int n);
    int cyc = 0;
    while (got < n && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("output_count", got, n);
    repeat (20) begin @(posedge clk); #1; end
    checkOutput("count_after_idle", got, n);
    checkOutput("idle_y_valid", int'(y_valid), 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("reset_y_valid", int'(y_valid), 0);
    checkOutput("reset_y_data", int'(y_data), 0);
    checkOutput("reset_x_ready", int'(x_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic runConstant(input int value);
    for (int k = 0; k < NPIX; k++) img[k] = value;
    startTest();
    buildExpected(0);
    applyStimulus(0, NPIX);
    waitOutputs(NPIX);
  endtask

  initial begin
    y_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      y_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scores every handshake and checks that stalled outputs hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", int'(y_valid), 1);
        checkOutput("stall_data", int'(y_data), int'(prev_data));
      end
      if (y_valid && !first_seen) begin
        first_seen = 1'b1;
        checkOutput("first_latency", acc_cnt, LAG + 1);
      end
      if (y_valid && y_ready) begin
        if (got < exp_q.size()) begin
          checkOutput($sformatf("y_data[%0d]", got), int'(y_data), exp_q[got]);
          checkOutput($sformatf("y_valid_frac[%0d]", got), int'(y_valid_f), 1);
          checkOutput($sformatf("y_data_frac[%0d]", got), int'(y_data_f), exp_f[got]);
        end else begin
          checkOutput("extra_output", got, exp_q.size());
        end
        got++;
      end
      prev_stall = y_valid && !y_ready;
      prev_data  = y_data;
    end
  end

  initial begin
    rst        = 1'b1;
    x_valid    = 1'b0;
    x_data     = '0;
    rand_ready = 1'b0;
    gaps       = 1'b0;
    setKernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    startTest();
    #2;
    doReset();

    $display("[TB] identity kernel on ramp");
    for (int k = 0; k < NPIX; k++) img[k] = k * 5;
    startTest();
    buildExpected(0);
    applyStimulus(0, NPIX);
    waitOutputs(NPIX);

    $display("[TB] sharpen, box, negative centre and edge kernels on constant images");
    setKernel(0, -1, 0, -1, 5, -1, 0, -1, 0);
    runConstant(100);
    setKernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
    runConstant(10);
    setKernel(0, 0, 0, 0, -1, 0, 0, 0, 0);
    runConstant(50);
    setKernel(-1, -1, -1, -1, 8, -1, -1, -1, -1);
    runConstant(20);

    $display("[TB] identity on ramp with random stalls and input gaps");
    rand_ready = 1'b1;
    gaps       = 1'b1;
    setKernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < NPIX; k++) img[k] = k * 5;
    startTest();
    buildExpected(0);
    applyStimulus(0, NPIX);
    waitOutputs(NPIX);

    $display("[TB] random kernel and image with stalls");
    for (int i = 0; i < 9; i++) kern[i/3][i%3] = 8'(int'($urandom_range(0, 16)) - 8);
    for (int k = 0; k < NPIX; k++) img[k] = int'($urandom_range(0, 255));
    startTest();
    buildExpected(0);
    applyStimulus(0, NPIX);
    waitOutputs(NPIX);

    $display("[TB] reset in mid frame, then a full frame");
    rand_ready = 1'b0;
    gaps       = 1'b0;
    for (int k = 0; k < NPIX; k++) img[k] = int'($urandom_range(0, 255));
    startTest();
    buildExpected(0);
    applyStimulus(0, 20);
    repeat (2) begin @(posedge clk); #1; end
    doReset();
    for (int k = 0; k < NPIX; k++) img[k] = int'($urandom_range(0, 255));
    startTest();
    buildExpected(0);
    applyStimulus(0, NPIX);
    waitOutputs(NPIX);

    $display("[TB] two back-to-back frames");
    rand_ready = 1'b1;
    for (int k = 0; k < 2*NPIX; k++) img[k] = int'($urandom_range(0, 255));
    startTest();
    buildExpected(0);
    buildExpected(NPIX);
    applyStimulus(0, NPIX);
    applyStimulus(NPIX, NPIX);
    rand_ready = 1'b0;
    waitOutputs(2*NPIX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/convolution_filter.md
# convolution_filter

Streaming 2-D convolution block for the pattern-recognition pipeline. It accepts one raster-ordered grayscale frame of pixels over a valid/ready input stream and convolves it with a run-time signed kernel, using zero padding at the borders. It emits exactly one saturated output pixel per input pixel, in the same raster order, over a valid/ready output stream. It sits between the grayscale converter and downstream feature/threshold stages.

## Interface
- `IMG_WIDTH`, 640: pixels per line.
- `IMG_HEIGHT`, 480: lines per frame.
- `KERNEL_H`, 3: kernel rows, odd, ≥3.
- `KERNEL_W`, 3: kernel columns, odd, ≥3.
- `W`, 8: pixel width and kernel coefficient width.
- `W_FRAC`, 0: fractional bits of the kernel coefficients.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `x_valid`  in  1  input pixel valid.
- `x_ready`  out  1  block accepts an input pixel.
- `x_data`  in  W  unsigned input pixel.
- `y_valid`  out  1  output pixel valid.
- `y_ready`  in  1  downstream accepts the output pixel.
- `y_data`  out  W  unsigned output pixel.
- `kernel`  in  signed W × [KERNEL_H][KERNEL_W]  unpacked coefficient array, `kernel[r][c]`; must be held stable for the whole frame.

## Operation
- Raster positions are k = 0..N-1, with N = IMG_WIDTH·IMG_HEIGHT. Row r = k / IMG_WIDTH; column c = k mod IMG_WIDTH.
- The block keeps KERNEL_H-1 line buffers of IMG_WIDTH pixels plus a KERNEL_H×KERNEL_W window register array.
- Output lag L = (KERNEL_H/2)·IMG_WIDTH + KERNEL_W/2. Output k is computed once position k+L has entered the window.
- Output(r,c) = Σ kernel[i][j]·p(r+i-KERNEL_H/2, c+j-KERNEL_W/2).
  - Any tap with row outside 0..IMG_HEIGHT-1 or column outside 0..IMG_WIDTH-1 contributes 0.
  - Columns never wrap into the adjacent line.
- Arithmetic:
  - Each pixel is zero-extended to W+1 bits signed.
  - Products are 2W+1 bits. The accumulator is 2W+1+$clog2(KERNEL_H·KERNEL_W) bits, so there is no internal overflow.
  - The sum is arithmetic-shifted right by W_FRAC, which rounds toward −∞.
  - The result is clamped to 0..2^W−1.
- FSM, two states:
  - STREAM: one advance per input handshake (x_valid && x_ready). On accepting input k = N−1, go to FLUSH.
  - FLUSH: x_ready = 0. Zero pixels are advanced internally, one per cycle in which the output slot is free, until output N−1 has been produced. Then clear all position counters and return to STREAM for the next frame.
- An advance at virtual position ≥ L loads the output register and sets y_valid.

## Timing
- Reset state: state = STREAM, counters = 0, y_valid = 0, y_data = 0. Line-buffer contents are don't-care because they are masked by the border logic.
- x_ready = (state == STREAM) && (!y_valid || y_ready). It is 1 immediately after reset.
- y_valid clears on a handshake (y_valid && y_ready) that is not accompanied by a new advance.
- With y_valid high and y_ready low, y_valid and y_data hold stable and nothing advances.
- Latency: output k is presented on the cycle after input k+L is accepted. The last L outputs come from FLUSH, at one per cycle under full throughput.
- Throughput is 1 pixel/cycle with y_ready held high. The first L input cycles produce no output.
- Asserting `rst` mid-frame discards the frame. The next accepted pixel is position 0.
- Changing `kernel` mid-frame gives undefined output values only. Handshake behaviour and pixel count are unaffected.

## Structure
- Package `convolution_filter_pkg` holds:
  - the state enum (STREAM, FLUSH);
  - a function computing the accumulator width from W, KERNEL_H and KERNEL_W;
  - the clamp/shift function.
- Sub-module `conv_line_buffer`: one IMG_WIDTH-deep shift/RAM line, written on advance. It is instantiated KERNEL_H−1 times.
- The top level holds the window, border masking, MAC tree, saturation, FSM and handshake.

## Test plan
- Bench uses IMG 8×6, 3×3 kernel, W = 8, W_FRAC = 0 unless noted.
- Identity kernel (centre 1, rest 0), ramp image -> output equals input, 48 outputs, then y_valid stays 0.
- Sharpen kernel [0 −1 0; −1 5 −1; 0 −1 0] on constant 100 -> interior 100, non-corner edge 200, corner 300 saturated to 255.
- Box kernel (all 1) on constant 10 -> interior 90, edge 60, corner 40. The same case with W_FRAC = 3 -> interior 11, edge 7, corner 5.
- Kernel centre −1 on constant 50 -> all outputs 0 (negative clamp). Edge kernel [−1…8…−1] on constant 20 -> interior 0, edge 60, corner 100.
- Random y_ready (50 %) and random x_valid gaps, ramp image -> outputs bit-identical to the stall-free run, y_data stable while stalled, exactly 48 outputs.
- Reset asserted after 20 inputs, then a full frame -> exactly 48 correct outputs, with no leftover from the aborted frame. Two back-to-back frames -> 96 outputs.
